uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have parameter BAUDRATE, default 115200: line bit rate.
REQ-003 SHALL have parameter CLK_FREQ_MHZ, default 125: clk frequency.
REQ-004 SHALL have parameter BAUDRATE_COUNT, default CLK_FREQ_MHZ*1_000_000/BAUDRATE: clk cycles per bit.
REQ-005 SHALL have localparam HALF_COUNT = BAUDRATE_COUNT/2: cycles from start edge to mid-start sample.
REQ-006 SHALL have port clk, input, 1: single clock.
REQ-007 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-008 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-009 SHALL have port data_o, output, DATA_WIDTH: last good received byte.
REQ-010 SHALL have port rx_valid, output, 1: one-cycle pulse when data_o updates.
REQ-011 SHALL have port rx_busy, output, 1: high whenever state != IDLE.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s) and keep one further delayed copy (rx_d) for edge detection.
REQ-014 SHALL use states IDLE, START, DATA, STOP with a single baud_cnt counter, cleared in IDLE and on every state change.
REQ-015 IDLE: rx_d==1 && rx_s==0 (falling edge) SHALL move to START; a line that stays low SHALL NOT trigger a frame.
REQ-016 START: at baud_cnt==HALF_COUNT-1, rx_s==0 SHALL move to DATA; rx_s==1 SHALL be treated as a glitch and return to IDLE with no output pulse.
REQ-017 DATA: at each baud_cnt==BAUDRATE_COUNT-1 (mid-bit), SHALL store rx_s LSB-first into the shift register and increment bit_cnt; after bit DATA_WIDTH-1, SHALL move to STOP.
REQ-018 STOP: at baud_cnt==BAUDRATE_COUNT-1, rx_s==1 SHALL load data_o from the shift register, pulse rx_valid for one cycle and return to IDLE.
REQ-019 STOP: at the same sample, rx_s==0 SHALL pulse frame_err for one cycle, leave data_o unchanged and return to IDLE.
REQ-020 After a frame error, SHALL NOT start a new frame until the line has gone high and then seen a new falling edge.
REQ-021 rx_valid and frame_err SHALL be registered, mutually exclusive, and asserted in the cycle after the stop sample.
REQ-022 data_o SHALL hold its value between rx_valid pulses.
REQ-023 Latency from the rx falling edge to rx_valid SHALL be 3 + HALF_COUNT + (DATA_WIDTH+1)*BAUDRATE_COUNT cycles, +/-1.
REQ-024 baud_cnt width SHALL be $clog2(BAUDRATE_COUNT)+1; bit_cnt width SHALL be $clog2(DATA_WIDTH)+1; no counter SHALL wrap inside a state.
REQ-025 rx_busy SHALL be combinational from state.

Reset
REQ-026 rst SHALL be sampled on posedge clk only.
REQ-027 Reset SHALL drive: state=IDLE, synchronizer flops=1, rx_d=1, counters=0, shift register=0, data_o=0, rx_valid=0, frame_err=0.
REQ-028 Reset mid-frame SHALL abort the frame with no rx_valid or frame_err pulse.
REQ-029 Reception SHALL resume on the next falling edge after rst deasserts.

Structure
REQ-030 Package uart_pkg SHALL hold the state encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and the default BAUDRATE and CLK_FREQ_MHZ, shared with the transmitter.
REQ-031 The synchronizer and edge detector SHALL be one sub-module, uart_sync (in: clk, rst, async_i; out: sync_o, fall_o).
REQ-032 The remaining FSM and datapath SHALL live in uart_rx.

Verification (BAUDRATE_COUNT=16 override; bit time = 16 clk)
REQ-033 Send 0xA5 with stop=1 -> exactly one rx_valid pulse with data_o=0xA5, frame_err=0, rx_busy low afterwards.
REQ-034 Send 0x00 then 0xFF back-to-back (no idle gap) -> two rx_valid pulses, data_o=0x00 then 0xFF.
REQ-035 Low pulse of 4 clk on idle line -> no pulse, back in IDLE within 12 clk, data_o unchanged.
REQ-036 Send 0x3C with stop=0 and line held low for 2 bit times -> frame_err pulse, no rx_valid, data_o keeps its previous value, no new frame until rise then fall.
REQ-037 Assert rst during bit 4 of 0x5A -> no output pulse, all outputs at reset values; next frame 0x81 -> data_o=0x81.
REQ-038 Sample bits shifted at +/-3 clk (line jitter) with 0x96 -> data_o=0x96.

Source files
------------

// File: rtl/uart_pkg.sv
// ---- uart_pkg : state encodings and default line settings shared by rx/tx ----
// ---- rev 1.0 -----------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int DEFAULT_BAUDRATE     = 115200;
  localparam int DEFAULT_CLK_FREQ_MHZ = 125;

  function automatic int baud_count(input int clk_freq_mhz, input int baudrate);
    return (clk_freq_mhz * 1_000_000) / baudrate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ---- uart_sync : 2-flop synchronizer plus one delayed copy for falling-edge detect ----
// ---- rev 1.0 --------------------------------------------------------------------------
`default_nettype none

module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta;
  logic sync_q;
  logic delay_q;

  // Flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= 1'b1;
      sync_q  <= 1'b1;
      delay_q <= 1'b1;
    end else begin
      meta    <= async_i;
      sync_q  <= meta;
      delay_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = delay_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---- uart_rx : mid-bit sampling UART receiver, LSB first, one stop bit ----
// ---- rev 1.0 --------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BAUDRATE       = DEFAULT_BAUDRATE,
  parameter int CLK_FREQ_MHZ   = DEFAULT_CLK_FREQ_MHZ,
  parameter int BAUDRATE_COUNT = baud_count(CLK_FREQ_MHZ, BAUDRATE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  frame_err
);

  localparam int HALF_COUNT = BAUDRATE_COUNT / 2;
  localparam int BAUD_W     = $clog2(BAUDRATE_COUNT) + 1;
  localparam int BIT_W      = $clog2(DATA_WIDTH) + 1;

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_COUNT - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(BAUDRATE_COUNT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  uart_state_e state;
  uart_state_e next_state;

  logic                  rx_s;
  logic                  rx_fall;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  logic half_hit;
  logic full_hit;
  logic shift_en;
  logic stop_ok;
  logic stop_bad;

  uart_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx),
    .sync_o  (rx_s),
    .fall_o  (rx_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    half_hit   = (baud_cnt == HALF_LAST);
    full_hit   = (baud_cnt == FULL_LAST);
    shift_en   = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        // Edge, not level: a line stuck low (e.g. after a framing error) stays idle.
        if (rx_fall) begin
          next_state = START;
        end
      end
      START: begin
        if (half_hit) begin
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_hit) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            next_state = STOP;
          end
        end
      end
      STOP: begin
        if (full_hit) begin
          stop_ok    = rx_s;
          stop_bad   = ~rx_s;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data_o    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // The counter restarts at each data sample so it times the next mid-bit point.
      if (state == IDLE || next_state != state || shift_en) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state != DATA || next_state != state) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
      end

      if (stop_ok) begin
        data_o <= shreg;
      end
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---- tb_uart_rx : directed frames with a scoreboard monitor on rx_valid/frame_err ----
// ---- rev 1.0 -------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int BIT_T = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_o;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .DATA_WIDTH     (8),
    .BAUDRATE_COUNT (BIT_T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_o    (data_o),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit edges after the start edge are displaced alternately by +jit / -jit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int jit);
    int e_prev;
    int e_next;
    e_prev = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      rx = 1'b0;
      else if (k == 9) rx = stop_bit;
      else             rx = b[k-1];
      if (k == 9)            e_next = 0;
      else if ((k % 2) == 0) e_next = jit;
      else                   e_next = -jit;
      wait_clks(BIT_T + e_next - e_prev);
      e_prev = e_next;
    end
  endtask

  task automatic expect_good(input logic [7:0] b);
    exp_t e;
    e.err  = 1'b0;
    e.data = b;
    exp_q.push_back(e);
    last_good = b;
  endtask

  task automatic expect_err();
    exp_t e;
    e.err  = 1'b1;
    e.data = last_good;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rx_valid === 1'b1 || frame_err === 1'b1) begin
      exp_t e;
      checks++;
      if (rx_valid === 1'b1 && frame_err === 1'b1) begin
        failures++;
        $display("FAIL pulse_exclusive rx_valid=%b frame_err=%b required one only", rx_valid, frame_err);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse rx_valid=%b frame_err=%b data_o=%0h required no pulse",
                 rx_valid, frame_err, data_o);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.err || data_o !== e.data) begin
          failures++;
          $display("FAIL scoreboard frame_err=%b data_o=%0h required frame_err=%b data_o=%0h",
                   frame_err, data_o, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clks(4);
    check("reset_data",   data_o,    0);
    check("reset_valid",  rx_valid,  0);
    check("reset_err",    frame_err, 0);
    check("reset_busy",   rx_busy,   0);
    rst = 1'b0;
    wait_clks(4);

    // Single clean frame
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, 0);
    wait_clks(4);
    check("a5_data", data_o,  8'hA5);
    check("a5_busy", rx_busy, 0);
    wait_clks(BIT_T);

    // Back-to-back frames with no idle gap
    expect_good(8'h00);
    send_frame(8'h00, 1'b1, 0);
    expect_good(8'hFF);
    send_frame(8'hFF, 1'b1, 0);
    wait_clks(4);
    check("b2b_data", data_o, 8'hFF);
    wait_clks(BIT_T);

    // Short low glitch on the idle line
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(8);
    check("glitch_busy", rx_busy, 0);
    check("glitch_data", data_o,  8'hFF);
    wait_clks(BIT_T);

    // Bad stop bit, line kept low for a further bit time
    expect_err();
    send_frame(8'h3C, 1'b0, 0);
    check("ferr_busy_low_line", rx_busy, 0);
    wait_clks(BIT_T);
    check("ferr_busy_still_low", rx_busy, 0);
    check("ferr_data_kept",      data_o,  8'hFF);
    rx = 1'b1;
    wait_clks(BIT_T);
    check("ferr_busy_after_rise", rx_busy, 0);
    expect_good(8'h3C);
    send_frame(8'h3C, 1'b1, 0);
    wait_clks(4);
    check("after_ferr_data", data_o, 8'h3C);
    wait_clks(BIT_T);

    // Reset in the middle of bit 4 of 0x5A
    rx = 1'b0;
    wait_clks(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h5A >> i) & 8'h01) != 0;
      wait_clks(BIT_T);
    end
    rx = 1'b1;
    wait_clks(BIT_T / 2);
    rst = 1'b1;
    wait_clks(2);
    check("midrst_data",  data_o,    0);
    check("midrst_valid", rx_valid,  0);
    check("midrst_err",   frame_err, 0);
    check("midrst_busy",  rx_busy,   0);
    rst = 1'b0;
    last_good = 8'h00;
    wait_clks(BIT_T);
    check("postrst_busy", rx_busy, 0);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1, 0);
    wait_clks(4);
    check("postrst_data", data_o, 8'h81);
    wait_clks(BIT_T);

    // Jittered bit edges
    expect_good(8'h96);
    send_frame(8'h96, 1'b1, 3);
    wait_clks(4);
    check("jitter_data", data_o,  8'h96);
    check("jitter_busy", rx_busy, 0);

    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
